// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a hardwired-zero r0 and a
// per-register busy scoreboard for RAW hazard detection at decode.
//
// Optional feature macro: REGFILE_SB_WRITE_BYPASS_EN
//   defined   -> a same-cycle write is forwarded to any read port addressing it
//   undefined -> reads return stored state; new data appears the next cycle
module regfile_sb #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_busy,
   input  logic                we,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                issue_valid,
   input  logic [AW-1:0]       issue_rd,
   input  logic                flush,
   output logic [AW:0]         busy_count
);

   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;

   logic wr_en;      // effective storage write (r0 is never written)
   logic set_en;     // effective issue (r0 is never marked busy)
   logic same_reg;   // issue and write target the same register this edge
   logic set_new;    // busy bit goes 0 -> 1
   logic clr_new;    // busy bit goes 1 -> 0

   assign wr_en    = we && (wr_addr != '0);
   assign set_en   = issue_valid && (issue_rd != '0);
   assign same_reg = set_en && (issue_rd == wr_addr);
   assign set_new  = set_en && !busy[issue_rd];
   // A clear is cancelled when the same register is re-issued on this edge:
   // the newer producer owns it.
   assign clr_new  = wr_en && busy[wr_addr] && !same_reg;

   // Architectural storage, cleared asynchronously.
   // NOTE: the whole array is reset because clearing all storage is a
   // functional requirement; this forces flops rather than a RAM macro.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Next busy vector: clear first, then set, so a same-register issue wins.
   // NOTE: busy_next is given a full default before any conditional update,
   // which keeps this block purely combinational (no latch).
   always_comb begin
      busy_next = busy;
      if (wr_en) begin
         busy_next[wr_addr] = 1'b0;
      end
      if (set_en) begin
         busy_next[issue_rd] = 1'b1;
      end
   end

   // Scoreboard and its incrementally maintained population count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy       <= '0;
         busy_count <= '0;
      end else if (flush) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_next;
         busy_count <= busy_count + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_new};
      end
   end

   // Read ports: combinational, r0 forced to zero.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] stored;

      assign a      = rs_addr[i*AW +: AW];
      assign stored = (a == '0) ? '0 : regs[a];

`ifdef REGFILE_SB_WRITE_BYPASS_EN
      logic hit;

      // Forward the in-flight write; the register is only still busy if it
      // is being re-issued in the same cycle.
      assign hit                    = wr_en && (a == wr_addr);
      assign rs_data[i*XLEN +: XLEN] = hit ? wr_data : stored;
      assign rs_busy[i]             = hit ? same_reg : busy[a];
`else
      assign rs_data[i*XLEN +: XLEN] = stored;
      assign rs_busy[i]             = busy[a];
`endif
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven self-checking bench for regfile_sb
// (default parameters: XLEN=64, NREGS=32, NRD=2). Honours
// REGFILE_SB_WRITE_BYPASS_EN for the same-cycle read expectations.
module tb_regfile_sb;

   logic        clk;
   logic        reset_n;
   logic [9:0]  rs_addr;
   logic [127:0] rs_data;
   logic [1:0]  rs_busy;
   logic        we;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        flush;
   logic [5:0]  busy_count;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_sb dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rs_addr     (rs_addr),
      .rs_data     (rs_data),
      .rs_busy     (rs_busy),
      .we          (we),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .flush       (flush),
      .busy_count  (busy_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic        iv;
      logic [4:0]  ird;
      logic        fl;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [1:0]  b;
      logic [5:0]  cnt;
   } vec_t;

   vec_t vecs [16];
   vec_t exp_q [$];

   function automatic vec_t mk(input string name, input logic w, input logic [4:0] wa,
                               input logic [63:0] wd, input logic iv, input logic [4:0] ird,
                               input logic fl, input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic [63:0] d0, input logic [63:0] d1,
                               input logic [1:0] b, input logic [5:0] cnt);
      vec_t v;
      v.name = name; v.we = w; v.wa = wa; v.wd = wd; v.iv = iv; v.ird = ird; v.fl = fl;
      v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1; v.b = b; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one vector for one edge, then read back with write-side inputs idle.
   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge clk);
      we = v.we; wr_addr = v.wa; wr_data = v.wd;
      issue_valid = v.iv; issue_rd = v.ird; flush = v.fl;
      rs_addr = {v.ra1, v.ra0};
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      we = 1'b0; issue_valid = 1'b0; flush = 1'b0;
      #1;
      if (exp_q.size() == 0) begin
         check({v.name, "_queue"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         check({e.name, "_d0"},  rs_data[63:0],   e.d0);
         check({e.name, "_d1"},  rs_data[127:64], e.d1);
         check({e.name, "_b"},   {62'd0, rs_busy}, {62'd0, e.b});
         check({e.name, "_cnt"}, {58'd0, busy_count}, {58'd0, e.cnt});
      end
   endtask

   initial begin
      vecs[0]  = mk("wr_r5",        1, 5,  64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0, 5, 0, 64'hDEADBEEF_CAFEF00D, 2'b00, 0);
      vecs[1]  = mk("wr_r0",        1, 0,  64'h1234, 0, 0,  0, 0,  5, 0, 64'hDEADBEEF_CAFEF00D, 2'b00, 0);
      vecs[2]  = mk("iss_r3",       0, 0,  64'h0,    1, 3,  0, 3,  7, 0,     0,     2'b01, 1);
      vecs[3]  = mk("iss_r7",       0, 0,  64'h0,    1, 7,  0, 3,  7, 0,     0,     2'b11, 2);
      vecs[4]  = mk("wr_r3",        1, 3,  64'h33,   0, 0,  0, 3,  7, 64'h33, 0,    2'b10, 1);
      vecs[5]  = mk("iss_wr_r7",    1, 7,  64'h77,   1, 7,  0, 7,  3, 64'h77, 64'h33, 2'b01, 1);
      vecs[6]  = mk("clr_idle_r4",  1, 4,  64'h44,   0, 0,  0, 4,  7, 64'h44, 64'h77, 2'b10, 1);
      vecs[7]  = mk("reiss_r7",     0, 0,  64'h0,    1, 7,  0, 7,  4, 64'h77, 64'h44, 2'b01, 1);
      vecs[8]  = mk("iss_r1_wr_r7", 1, 7,  64'h78,   1, 1,  0, 1,  7, 0,     64'h78, 2'b01, 1);
      vecs[9]  = mk("iss_r0",       0, 0,  64'h0,    1, 0,  0, 0,  1, 0,     0,     2'b10, 1);
      vecs[10] = mk("iss_r2",       0, 0,  64'h0,    1, 2,  0, 2,  1, 0,     0,     2'b11, 2);
      vecs[11] = mk("iss_r10",      0, 0,  64'h0,    1, 10, 0, 10, 2, 0,     0,     2'b11, 3);
      vecs[12] = mk("iss_r11",      0, 0,  64'h0,    1, 11, 0, 11, 1, 0,     0,     2'b11, 4);
      vecs[13] = mk("flush",        1, 2,  64'h55,   1, 9,  1, 9,  2, 0,     64'h55, 2'b00, 0);
      vecs[14] = mk("iss_wr_r12",   1, 12, 64'hC,    1, 12, 0, 12, 11, 64'hC, 0,    2'b01, 1);
      vecs[15] = mk("wr_r12",       1, 12, 64'hC0,   0, 0,  0, 12, 11, 64'hC0, 0,   2'b00, 0);

      reset_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
      issue_valid = 1'b0; issue_rd = '0; flush = 1'b0; rs_addr = '0;

      // Reset state, then every address reads zero and idle.
      #3;
      check("rst_cnt_during", {58'd0, busy_count}, 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         rs_addr = {a[4:0], a[4:0]};
         #1;
         check($sformatf("rst_d0_r%0d", a), rs_data[63:0], 64'd0);
         check($sformatf("rst_d1_r%0d", a), rs_data[127:64], 64'd0);
         check($sformatf("rst_b_r%0d", a), {62'd0, rs_busy}, 64'd0);
      end
      check("rst_cnt_after", {58'd0, busy_count}, 64'd0);

      // Table-driven main function.
      for (int i = 0; i < 16; i++) begin
         apply(vecs[i]);
      end

      // Counter upper bound: every non-zero register busy.
      for (int r = 1; r < 32; r++) begin
         @(negedge clk);
         issue_valid = 1'b1; issue_rd = r[4:0];
      end
      @(negedge clk);
      issue_valid = 1'b0;
      rs_addr = {5'd31, 5'd1};
      #1;
      check("sat_cnt", {58'd0, busy_count}, 64'd31);
      check("sat_busy", {62'd0, rs_busy}, 64'd3);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("sat_flush_cnt", {58'd0, busy_count}, 64'd0);

      // Same-cycle write and read of r10 (r10 holds 0x11 and is busy).
      we = 1'b1; wr_addr = 5'd10; wr_data = 64'h11;
      issue_valid = 1'b1; issue_rd = 5'd10;
      @(negedge clk);
      issue_valid = 1'b0;
      wr_data = 64'hA5;
      rs_addr = {5'd10, 5'd10};
      #1;
`ifdef REGFILE_SB_WRITE_BYPASS_EN
      check("byp_data", rs_data[63:0], 64'hA5);
      check("byp_busy", {63'd0, rs_busy[0]}, 64'd0);
`else
      check("byp_data", rs_data[63:0], 64'h11);
      check("byp_busy", {63'd0, rs_busy[0]}, 64'd1);
`endif
      issue_valid = 1'b1;
      #1;
      check("byp_busy_reissue", {63'd0, rs_busy[1]}, 64'd1);
      @(posedge clk);
      #1;
      we = 1'b0; issue_valid = 1'b0;
      #1;
      check("byp_next_data", rs_data[127:64], 64'hA5);
      check("byp_next_busy", {63'd0, rs_busy[1]}, 64'd1);
      check("byp_next_cnt", {58'd0, busy_count}, 64'd1);

      // Asynchronous reset in the middle of a write burst.
      @(negedge clk);
      we = 1'b1; wr_addr = 5'd20; wr_data = 64'hBB;
      issue_valid = 1'b1; issue_rd = 5'd22;
      rs_addr = {5'd22, 5'd20};
      @(posedge clk);
      #2;
      check("arst_pre_cnt", {58'd0, busy_count}, 64'd2);
      check("arst_pre_busy", {63'd0, rs_busy[1]}, 64'd1);
      wr_addr = 5'd23; wr_data = 64'hEE;
      reset_n = 1'b0;
      #1;
      check("arst_d0", rs_data[63:0], 64'd0);
      check("arst_busy", {62'd0, rs_busy}, 64'd0);
      check("arst_cnt", {58'd0, busy_count}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1; we = 1'b0; issue_valid = 1'b0;
      rs_addr = {5'd23, 5'd10};
      #1;
      check("arst_drop_wr", rs_data[127:64], 64'd0);
      check("arst_r10", rs_data[63:0], 64'd0);
      check("arst_post_cnt", {58'd0, busy_count}, 64'd0);

      if (exp_q.size() != 0) begin
         check("queue_drained", 64'(exp_q.size()), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle core's 64-bit, 2-read/1-write register file.
- Generalised in data width, register count and read-port count.
- Adds a hardwired-zero register 0 and an asynchronous clear of all storage.
- Adds a per-register busy scoreboard with an in-flight counter, for the planned pipelined core to detect RAW hazards at decode.

Parameters:
- XLEN, 64, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports, 1..4.
- AW, $clog2(NREGS), register address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rs_data  out  NRD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN].
- rs_busy  out  NRD  busy flag of the register addressed by each read port.
- we  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- issue_valid  in  1  marks issue_rd as pending (busy).
- issue_rd  in  AW  destination register of the issuing instruction.
- flush  in  1  synchronously clears all busy bits.
- busy_count  out  AW+1  number of registers currently busy.

Behaviour:
- Reset:
  - Clock is single, named clk. Reset is asynchronous and active-low, named reset_n.
  - While reset_n=0: all NREGS registers = 0, all busy bits = 0, busy_count = 0.
  - All outputs are combinational from state, so rs_data = 0, rs_busy = 0 and busy_count = 0 during reset and on the first cycle after it.
  - Reset asserted mid-operation discards any same-edge write or issue.
- Storage write:
  - On posedge clk with we=1 and wr_addr != 0: reg[wr_addr] <= wr_data.
  - Writes to address 0 are ignored; reg[0] always reads 0.
- Read:
  - Combinational, zero latency: rs_data[i] = reg[rs_addr[i]].
  - Address 0 always returns 0.
  - The next-edge write is visible on the following cycle, except as modified by the optional bypass.
- Scoreboard, per-register busy bit b[r], with b[0] fixed at 0:
  - set: issue_valid=1 and issue_rd != 0 sets b[issue_rd].
  - clear: we=1 and wr_addr != 0 clears b[wr_addr].
  - Set and clear on the same edge, same register: b stays 1, because the newer producer wins.
  - Set and clear on the same edge, different registers: both take effect.
  - Set on a register that is already busy: stays 1; no count change.
  - Clear on a register that is not busy: no effect; no count change.
  - flush=1: all b <= 0 and busy_count <= 0. Flush overrides issue and clear on the same edge. The storage write still occurs.
- Read-side flags: rs_busy[i] = b[rs_addr[i]]; always 0 for address 0.
- busy_count:
  - Registered counter, kept equal to popcount(b).
  - Updated incrementally: +1 on an effective 0->1 transition, -1 on an effective 1->0 transition; a net 0 when both occur on one edge.
  - Never wraps: maximum value NREGS-1, minimum 0.
- Width rules:
  - XLEN applies uniformly; no sign or zero extension inside the block.
  - Out-of-range addresses cannot occur because NREGS is a power of two.

Optional Feature:
- Macro: REGFILE_SB_WRITE_BYPASS_EN.
- Defined: when we=1, wr_addr != 0 and rs_addr[i] == wr_addr in the same cycle:
  - rs_data[i] = wr_data.
  - rs_busy[i] = 0, unless issue_valid=1 and issue_rd == wr_addr in that cycle.
  - Gives write-then-read in one cycle.
- Undefined: reads return the stored value and the current busy bit; the new data is visible from the next cycle.

Test Plan:
- Reset and read: drive reset_n=0 then release; read all addresses -> rs_data=0, rs_busy=0, busy_count=0.
- Write/read and zero register:
  - Write 0xDEADBEEF_CAFEF00D to r5, read r5 on port 1 next cycle -> that value.
  - Write 0x1234 to r0 -> r0 still reads 0.
- Scoreboard:
  - Issue r3, then r7 on consecutive cycles -> busy_count=2, rs_busy=1 for r3.
  - Write r3 -> busy_count=1, rs_busy for r3 = 0.
  - Same-edge issue r7 and write r7 -> r7 stays busy, count unchanged at 1.
- Flush: with 4 registers busy, assert flush together with issue r9 -> busy_count=0, r9 not busy. A same-edge write to r2 of 0x55 still lands (r2 reads 0x55).
- Async reset mid-operation: during a write burst, pulse reset_n low between clock edges -> registers, busy bits and busy_count clear immediately, without waiting for a clock edge.
- Bypass, run with the macro defined and undefined: same-cycle write r10=0xA5 and read r10:
  - Defined -> rs_data=0xA5, rs_busy=0.
  - Undefined -> old r10 value, then 0xA5 on the next cycle.
